// File: rtl/ring_output_scheduler.sv
// Per-link output scheduler: holds one packet per (source, VC) and shares the link on an even/odd phase.
// Latency: 2..3 cycles from accept to out_send without backpressure (registered link output).
// Backpressure: per-VC ready = entry empty; out_ready[p]=0 stalls VC p with its priority bit untouched.
module ring_output_scheduler #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  polarity,
  input  logic                  src0_send,
  output logic [1:0]            src0_ready,
  input  logic [DATA_WIDTH-1:0] src0_data,
  input  logic                  src1_send,
  output logic [1:0]            src1_ready,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  out_send,
  input  logic [1:0]            out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int VC_BIT = DATA_WIDTH - 1;

  // Per-source, per-VC single-entry buffers (index is the VC).
  logic [1:0]            full0;
  logic [1:0]            full1;
  logic [DATA_WIDTH-1:0] buf0 [2];
  logic [DATA_WIDTH-1:0] buf1 [2];

  // Rotating priority per VC: 0 favours through-traffic, 1 favours injection.
  logic [1:0] prio;
  logic [1:0] prio_next;

  logic vc0;
  logic vc1;
  logic accept0;
  logic accept1;
  logic req0;
  logic req1;
  logic link_free;
  logic grant0;
  logic grant1;

  // Ready comes only from registered state, so an entry drained this cycle cannot be refilled until next cycle.
  assign src0_ready = ~full0;
  assign src1_ready = ~full1;

  assign vc0     = src0_data[VC_BIT];
  assign vc1     = src1_data[VC_BIT];
  assign accept0 = src0_send & src0_ready[vc0];
  assign accept1 = src1_send & src1_ready[vc1];

  // Phase register: only the VC matching the current polarity may use the link this cycle.
  always_ff @(posedge clk) begin
    if (reset) polarity <= 1'b0;
    else       polarity <= ~polarity;
  end

  // Two-way arbitration for the active VC; priority flips to the loser on contention, falls back to src0 otherwise.
  always_comb begin
    req0      = full0[polarity];
    req1      = full1[polarity];
    link_free = out_ready[polarity];
    grant0    = 1'b0;
    grant1    = 1'b0;
    prio_next = prio;
    if (link_free) begin
      if (req0 && req1) begin
        if (prio[polarity]) grant1 = 1'b1;
        else                grant0 = 1'b1;
        prio_next[polarity] = ~prio[polarity];
      end else if (req0) begin
        grant0              = 1'b1;
        prio_next[polarity] = 1'b0;
      end else if (req1) begin
        grant1              = 1'b1;
        prio_next[polarity] = 1'b0;
      end
    end
  end

  // Priority bits; the inactive VC's bit is carried through unchanged by prio_next.
  always_ff @(posedge clk) begin
    if (reset) prio <= 2'b00;
    else       prio <= prio_next;
  end

  // Full flags: accepts only target empty entries and grants only full ones, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      full0 <= 2'b00;
      full1 <= 2'b00;
    end else begin
      if (accept0) full0[vc0]      <= 1'b1;
      if (grant0)  full0[polarity] <= 1'b0;
      if (accept1) full1[vc1]      <= 1'b1;
      if (grant1)  full1[polarity] <= 1'b0;
    end
  end

  // Buffer payloads need no reset: the full flags guard every read.
  always_ff @(posedge clk) begin
    if (accept0) buf0[vc0] <= src0_data;
    if (accept1) buf1[vc1] <= src1_data;
  end

  // Registered link output; data holds its last value when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_send <= 1'b0;
      out_data <= '0;
    end else begin
      out_send <= grant0 | grant1;
      if (grant0)      out_data <= buf0[polarity];
      else if (grant1) out_data <= buf1[polarity];
    end
  end

endmodule
